aes_round_engine: RTL and testbench
===================================

Name: aes_round_engine

Overview:
- Iterative AES-128 encryption engine: accepts a 128-bit plaintext block and key, runs the initial AddRoundKey plus 10 rounds, and returns the ciphertext.
- Generalises the single-round block: round keys are expanded on the fly, ROUNDS_PER_CYCLE rounds are unrolled per clock, and valid/ready handshakes are used on both sides.
- Sits between the block-level data path and the output buffer of the AES datapath.

Parameters:
- NUM_ROUNDS, 10, total rounds executed after the initial AddRoundKey; fixed at 10 for AES-128, other values are for test only.
- ROUNDS_PER_CYCLE, 1, rounds computed combinationally per clock; legal values 1, 2, 5, 10; must divide NUM_ROUNDS (elaboration-time error otherwise).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_data  in  128  plaintext; state byte 0 = in_data[127:120], column-major per FIPS-197.
- in_key  in  128  cipher key, same byte order.
- in_valid  in  1  in_data/in_key are valid.
- in_ready  out  1  engine can accept a block.
- out_data  out  128  ciphertext.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- busy  out  1  engine is in the ROUND state.

Behaviour:
- Reset (asynchronous, any state, including mid-operation): state=IDLE, in_ready=1, out_valid=0, out_data=0, busy=0, round counter=0, internal state and key registers=0. Any in-flight block is discarded.
- FSM states: IDLE, ROUND, DONE.
- IDLE: in_ready=1.
  - On in_valid&&in_ready: state_reg <= in_data ^ in_key (initial AddRoundKey); key_reg <= in_key; rcnt <= 0; go to ROUND.
- ROUND: in_ready=0, busy=1.
  - Each cycle apply ROUNDS_PER_CYCLE rounds. Each round: SubBytes, ShiftRows, MixColumns (MixColumns skipped when the global round index == NUM_ROUNDS), then AddRoundKey with the next expanded key.
  - Key expansion step uses rcon[global round index].
  - rcnt += ROUNDS_PER_CYCLE.
  - When rcnt reaches NUM_ROUNDS: out_data <= result; out_valid <= 1; go to DONE.
- DONE: out_valid=1 and out_data are held stable until out_ready. On out_valid&&out_ready: out_valid <= 0; go to IDLE. in_ready stays 0 in DONE (no overlap).
- Latency: accept edge to out_valid = NUM_ROUNDS/ROUNDS_PER_CYCLE cycles (10 for default). Throughput is at most one block per latency+2 cycles.
- out_ready held high in DONE: out_valid lasts exactly one cycle, and in_ready returns on the following cycle.
- in_valid while not in_ready: ignored; the input is not sampled.
- in_data/in_key changing during ROUND: no effect; the inputs are registered at accept.
- out_data keeps its last ciphertext after handshake until the next completion or reset.
- All arithmetic is GF(2^8) with polynomial 0x11B. xtime is implemented as a shift plus conditional XOR 0x1B. No integer carries.

Decomposition:
- Package aes_pkg holds:
  - 256-entry S-box constant function/table.
  - rcon array (01,02,04,08,10,20,40,80,1b,36).
  - xtime and MixColumns column function.
  - Typedef for a 16-byte state array, plus byte-index helper for ShiftRows.
- One sub-module, aes_round_step (combinational): one round plus one key-expansion step.
  - Inputs: state, key, rcon byte, final flag.
  - Outputs: next state, next key.
  - Instantiated ROUNDS_PER_CYCLE times in a generate chain.

Test Plan:
- FIPS-197 App. B: in_data=3243f6a8885a308d313198a2e0370734, in_key=2b7e151628aed2a6abf7158809cf4f3c, out_ready=1 -> out_data=3925841d02dc09fbdc118597196a0b32, out_valid exactly 10 cycles after accept, busy high 10 cycles.
- FIPS-197 App. C.1: in_data=00112233445566778899aabbccddeeff, in_key=000102030405060708090a0b0c0d0e0f -> out_data=69c4e0d86a7b0430d8cdb78070b4c55a; repeat with ROUNDS_PER_CYCLE=2 and 5 -> same result, latency 5 and 2 cycles.
- Backpressure: out_ready=0 for 20 cycles after completion -> out_valid and out_data stable, in_ready=0, a second in_valid ignored; raise out_ready -> single transfer, in_ready=1 next cycle.
- Reset mid-operation: assert rst at round 4 of App. B vector -> out_valid=0, in_ready=1, out_data=0 immediately; after release, App. C.1 vector gives correct ciphertext.
- Back-to-back: in_valid held high with App. B then App. C.1 vectors -> both ciphertexts correct in order, second accepted only after first handshake.
- Input change during ROUND: alter in_data/in_key every cycle after accept -> ciphertext matches the originally accepted vector.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: state typedef, FSM states, S-box, rcon,
// GF(2^8) xtime, the MixColumns column function and the ShiftRows index map.
package aes_pkg;

  // 16-byte AES state. Element 0 is the most significant byte, so a
  // 128-bit vector maps straight onto it: byte 0 = bits [127:120].
  typedef logic [0:15][7:0] aes_state_t;

  typedef enum logic [1:0] {
    AES_IDLE,
    AES_ROUND,
    AES_DONE
  } aes_fsm_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Round constant for 1-based round index; zero outside 1..10.
  function automatic logic [7:0] rcon_of(input logic [7:0] idx);
    case (idx)
      8'd1:    return 8'h01;
      8'd2:    return 8'h02;
      8'd3:    return 8'h04;
      8'd4:    return 8'h08;
      8'd5:    return 8'h10;
      8'd6:    return 8'h20;
      8'd7:    return 8'h40;
      8'd8:    return 8'h80;
      8'd9:    return 8'h1b;
      8'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Multiply by x in GF(2^8) mod 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One MixColumns column; row 0 in bits [31:24].
  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // ShiftRows source byte for destination byte i (i = 4*col + row).
  function automatic int unsigned shift_src(input int unsigned i);
    return (((i / 4) + (i % 4)) % 4) * 4 + (i % 4);
  endfunction

endpackage

// File: rtl/aes_round_step.sv
// One combinational AES round (SubBytes, ShiftRows, optional MixColumns,
// AddRoundKey) together with the matching key-expansion step.
module aes_round_step
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] key_i,
  input  logic [7:0]   rcon_i,
  input  logic         final_i,
  output logic [127:0] state_o,
  output logic [127:0] key_o
);

  aes_state_t  st_in;
  aes_state_t  sub_s;
  aes_state_t  shf_s;
  logic [127:0] shf_v;
  logic [127:0] mix_v;
  logic [31:0]  w3;
  logic [31:0]  temp;
  logic [31:0]  n0, n1, n2, n3;

  assign st_in = state_i;

  for (genvar gi = 0; gi < 16; gi++) begin : g_sub_shift
    localparam int unsigned SRC = shift_src(gi);
    assign sub_s[gi] = sbox(st_in[gi]);
    assign shf_s[gi] = sub_s[SRC];
  end

  assign shf_v = shf_s;

  for (genvar gi = 0; gi < 4; gi++) begin : g_mix
    assign mix_v[127-32*gi -: 32] = mix_col(shf_v[127-32*gi -: 32]);
  end

  // Next round key: RotWord, SubWord and rcon on the last word, then chain.
  assign w3   = key_i[31:0];
  assign temp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
                ^ {rcon_i, 24'h000000};
  assign n0   = key_i[127:96] ^ temp;
  assign n1   = key_i[95:64]  ^ n0;
  assign n2   = key_i[63:32]  ^ n1;
  assign n3   = key_i[31:0]   ^ n2;
  assign key_o = {n0, n1, n2, n3};

  // The last round skips MixColumns.
  assign state_o = (final_i ? shf_v : mix_v) ^ key_o;

endmodule

// File: rtl/aes_round_engine.sv
// Iterative AES-128 encryptor: initial AddRoundKey at accept, then
// ROUNDS_PER_CYCLE unrolled rounds per clock, with valid/ready on both sides.
module aes_round_engine
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS       = 10,
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  localparam int CW = $clog2(NUM_ROUNDS + 1);

  if (ROUNDS_PER_CYCLE < 1 || (NUM_ROUNDS % ROUNDS_PER_CYCLE) != 0) begin : g_bad_cfg
    $error("aes_round_engine: ROUNDS_PER_CYCLE must divide NUM_ROUNDS");
  end

  aes_fsm_t     fsm_q;
  logic [127:0] state_q;
  logic [127:0] key_q;
  logic [CW-1:0] rcnt_q;
  logic [CW-1:0] rcnt_d;
  logic [127:0] out_data_q;
  logic         out_valid_q;
  logic         in_ready_q;
  logic         busy_q;
  logic [127:0] round_state_d;
  logic [127:0] round_key_d;

  logic [127:0] chain_state [ROUNDS_PER_CYCLE+1];
  logic [127:0] chain_key   [ROUNDS_PER_CYCLE+1];

  assign chain_state[0] = state_q;
  assign chain_key[0]   = key_q;

  for (genvar gi = 0; gi < ROUNDS_PER_CYCLE; gi++) begin : g_rounds
    logic [7:0] round_idx;
    // 1-based global round index of this stage.
    assign round_idx = 8'(rcnt_q) + 8'(gi + 1);

    aes_round_step u_step (
      .state_i (chain_state[gi]),
      .key_i   (chain_key[gi]),
      .rcon_i  (rcon_of(round_idx)),
      .final_i (round_idx == 8'(NUM_ROUNDS)),
      .state_o (chain_state[gi+1]),
      .key_o   (chain_key[gi+1])
    );
  end

  assign round_state_d = chain_state[ROUNDS_PER_CYCLE];
  assign round_key_d   = chain_key[ROUNDS_PER_CYCLE];
  assign rcnt_d        = rcnt_q + CW'(ROUNDS_PER_CYCLE);

  // Control FSM with registered handshake outputs; reset drops any block in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= AES_IDLE;
      state_q     <= '0;
      key_q       <= '0;
      rcnt_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (fsm_q)
        AES_IDLE: begin
          if (in_valid && in_ready_q) begin
            state_q    <= in_data ^ in_key;
            key_q      <= in_key;
            rcnt_q     <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            fsm_q      <= AES_ROUND;
          end
        end
        AES_ROUND: begin
          state_q <= round_state_d;
          key_q   <= round_key_d;
          rcnt_q  <= rcnt_d;
          if (rcnt_d == CW'(NUM_ROUNDS)) begin
            out_data_q  <= round_state_d;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            fsm_q       <= AES_DONE;
          end
        end
        AES_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            fsm_q       <= AES_IDLE;
          end
        end
        default: fsm_q <= AES_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_aes_round_engine.sv
// Bench for aes_round_engine: three instances (1, 2 and 5 rounds per cycle)
// checked against FIPS-197 vectors and a byte-level reference AES model.
module tb_aes_round_engine;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] in_data   [3];
  logic [127:0] in_key    [3];
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] out_data  [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic         busy      [3];

  int tests = 0;
  int fails = 0;
  logic [7:0] sbox_tab [256];

  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    aes_round_engine #(
      .NUM_ROUNDS       (10),
      .ROUNDS_PER_CYCLE (gi == 0 ? 1 : (gi == 1 ? 2 : 5))
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data[gi]),
      .in_key    (in_key[gi]),
      .in_valid  (in_valid[gi]),
      .in_ready  (in_ready[gi]),
      .out_data  (out_data[gi]),
      .out_valid (out_valid[gi]),
      .out_ready (out_ready[gi]),
      .busy      (busy[gi])
    );
  end

  function automatic int rpc_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 2 : 5);
  endfunction

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (byte arrays, FIPS-197 rules) --------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic       hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b  = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  // S-box derived from the multiplicative inverse plus the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0]  st  [16];
    logic [7:0]  tmp [16];
    logic [31:0] w   [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
        t = t ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ key[127-8*i -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) st[i] = sbox_tab[st[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          tmp[4*c+row] = st[4*((c+row)%4)+row];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          if (r < 10)
            st[4*c+row] = gmul(8'h02, tmp[4*c+row]) ^ gmul(8'h03, tmp[4*c+(row+1)%4])
                        ^ tmp[4*c+(row+2)%4] ^ tmp[4*c+(row+3)%4];
          else
            st[4*c+row] = tmp[4*c+row];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          st[4*c+row] = st[4*c+row] ^ w[4*r+c][31-8*row -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- stimulus helpers ------------------------------------
  // Wait (bounded) for out_valid, counting cycles and busy cycles since accept.
  task automatic wait_out(input int d, input bit scramble, output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (!out_valid[d] && lat < 64) begin
      if (busy[d]) bcnt++;
      if (scramble) begin
        in_data[d] = rand128();
        in_key[d]  = rand128();
      end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Present one block, check latency/busy/ciphertext; completes the
  // handshake immediately when out_ready is already high.
  task automatic run_block(input int d, input logic [127:0] pt, input logic [127:0] key,
                           input logic [127:0] exp, input bit scramble, input string tag);
    int lat, bcnt;
    in_data[d]  = pt;
    in_key[d]   = key;
    in_valid[d] = 1'b1;
    check_eq({tag, "_in_ready"}, 128'(in_ready[d]), 128'(1'b1));
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    wait_out(d, scramble, lat, bcnt);
    check_eq({tag, "_latency"}, 128'(lat), 128'(10 / rpc_of(d)));
    check_eq({tag, "_busy_cycles"}, 128'(bcnt), 128'(10 / rpc_of(d)));
    check_eq({tag, "_ct"}, out_data[d], exp);
    $display("[TB] %s dut%0d pt=%h key=%h ct=%h lat=%0d", tag, d, pt, key, out_data[d], lat);
    if (out_ready[d]) begin
      @(posedge clk); #1;
      check_eq({tag, "_ov_drop"}, 128'(out_valid[d]), 128'(1'b0));
      check_eq({tag, "_in_ready_back"}, 128'(in_ready[d]), 128'(1'b1));
    end
  endtask

  // Hold out_ready low for n cycles (with ignored in_valid), then release.
  task automatic hold_release(input int d, input int n, input logic [127:0] exp, input string tag);
    for (int i = 0; i < n; i++) begin
      in_valid[d] = 1'b1;
      in_data[d]  = rand128();
      in_key[d]   = rand128();
      @(posedge clk); #1;
      check_eq({tag, "_hold_ov"}, 128'(out_valid[d]), 128'(1'b1));
      check_eq({tag, "_hold_data"}, out_data[d], exp);
      check_eq({tag, "_hold_in_ready"}, 128'(in_ready[d]), 128'(1'b0));
      check_eq({tag, "_hold_busy"}, 128'(busy[d]), 128'(1'b0));
    end
    in_valid[d]  = 1'b0;
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    check_eq({tag, "_rel_ov"}, 128'(out_valid[d]), 128'(1'b0));
    check_eq({tag, "_rel_in_ready"}, 128'(in_ready[d]), 128'(1'b1));
    check_eq({tag, "_keep_data"}, out_data[d], exp);
    @(posedge clk); #1;
    check_eq({tag, "_no_accept"}, 128'(busy[d]), 128'(1'b0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bcnt;
    logic [127:0] pt, key, exp;
    for (int d = 0; d < 3; d++) begin
      in_data[d]   = '0;
      in_key[d]    = '0;
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b1;
    end
    build_sbox();

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    for (int d = 0; d < 3; d++) begin
      check_eq("rst_in_ready", 128'(in_ready[d]), 128'(1'b1));
      check_eq("rst_out_valid", 128'(out_valid[d]), 128'(1'b0));
      check_eq("rst_out_data", out_data[d], 128'h0);
      check_eq("rst_busy", 128'(busy[d]), 128'(1'b0));
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Known-answer vectors
    run_block(0, B_PT, B_KEY, B_CT, 1'b0, "appB");
    for (int d = 0; d < 3; d++) run_block(d, C_PT, C_KEY, C_CT, 1'b0, "appC1");

    // Backpressure: 20 cycles of out_ready low
    out_ready[0] = 1'b0;
    run_block(0, B_PT, B_KEY, B_CT, 1'b0, "bp");
    hold_release(0, 20, B_CT, "bp");

    // Reset at round 4
    in_data[0] = B_PT; in_key[0] = B_KEY; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_eq("midrst_out_valid", 128'(out_valid[0]), 128'(1'b0));
    check_eq("midrst_in_ready", 128'(in_ready[0]), 128'(1'b1));
    check_eq("midrst_out_data", out_data[0], 128'h0);
    check_eq("midrst_busy", 128'(busy[0]), 128'(1'b0));
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    run_block(0, C_PT, C_KEY, C_CT, 1'b0, "postrst");

    // Back-to-back with in_valid held high
    in_data[0] = B_PT; in_key[0] = B_KEY; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_data[0] = C_PT; in_key[0] = C_KEY;
    wait_out(0, 1'b0, lat, bcnt);
    check_eq("b2b_first_ct", out_data[0], B_CT);
    check_eq("b2b_first_in_ready", 128'(in_ready[0]), 128'(1'b0));
    @(posedge clk); #1;
    check_eq("b2b_gap_in_ready", 128'(in_ready[0]), 128'(1'b1));
    check_eq("b2b_gap_busy", 128'(busy[0]), 128'(1'b0));
    @(posedge clk); #1;
    check_eq("b2b_second_busy", 128'(busy[0]), 128'(1'b1));
    in_valid[0] = 1'b0;
    wait_out(0, 1'b0, lat, bcnt);
    check_eq("b2b_second_ct", out_data[0], C_CT);
    $display("[TB] b2b dut0 second ct=%h", out_data[0]);
    @(posedge clk); #1;

    // Inputs change every cycle during ROUND
    run_block(0, C_PT, C_KEY, C_CT, 1'b1, "scramble");

    // Randomized blocks against the reference model
    for (int n = 0; n < 24; n++) begin
      int d;
      d   = n % 3;
      pt  = rand128();
      key = rand128();
      exp = aes_ref(pt, key);
      out_ready[d] = 1'($urandom_range(0, 1));
      if (out_ready[d]) begin
        run_block(d, pt, key, exp, 1'($urandom_range(0, 1)), "rand");
      end else begin
        run_block(d, pt, key, exp, 1'($urandom_range(0, 1)), "rand");
        hold_release(d, int'($urandom_range(0, 3)), exp, "rand");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
